// File: rtl/recog_scheduler.sv
// recog_scheduler: feeds queued character boxes to the single-box recognizer
// one at a time, waits for a run of identical recognizer codes (or gives up
// after a frame budget) and streams one result per box downstream.
module recog_scheduler #(
  parameter int          DEPTH     = 8,
  parameter int          AGREE     = 3,
  parameter int          MAX_TRIES = 10,
  parameter logic [10:0] SAMPLE_X  = 11'd1212,
  parameter logic [9:0]  SAMPLE_Y  = 10'd711,
  parameter logic [10:0] SWITCH_X  = 11'd1230,
  parameter logic [9:0]  SWITCH_Y  = 10'd713,
  localparam int         IW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          box_valid,
  output logic          box_ready,
  input  logic [10:0]   box_left,
  input  logic [10:0]   box_right,
  input  logic [9:0]    box_top,
  input  logic [9:0]    box_bottom,
  input  logic          box_tag,
  input  logic [10:0]   RGB_x_Src,
  input  logic [9:0]    RGB_y_Src,
  input  logic [3:0]    rec_num,
  output logic [10:0]   left,
  output logic [10:0]   right,
  output logic [9:0]    top,
  output logic [9:0]    bottom,
  output logic          tag,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [3:0]    res_num,
  output logic [IW-1:0] res_idx,
  output logic          res_stable,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, WAIT_SW, RUN, EMIT} state_t;

  localparam int         BW      = 43;
  localparam logic [3:0] NO_CODE = 4'b1011;
  localparam logic [3:0] AGREE_C = 4'(AGREE);
  localparam logic [3:0] MAX_C   = 4'(MAX_TRIES);
  localparam logic [IW:0] FULL_C = (IW+1)'(DEPTH);

  // Box FIFO storage: {left, right, top, bottom, tag}
  logic [BW-1:0] mem [DEPTH];

  logic [IW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic [BW-1:0] box_q, box_d;
  logic [3:0]    tries_q, tries_d;
  logic [3:0]    streak_q, streak_d;
  logic [3:0]    last_q, last_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          res_valid_q, res_valid_d;
  logic [3:0]    res_num_q, res_num_d;
  logic          res_stable_q, res_stable_d;
  logic          done_q, done_d;

  logic          push, pop, full, sample_pt, switch_pt;
  logic [BW-1:0] push_data, head;
  logic [3:0]    tries_n, streak_n, last_n;

  assign full      = (count_q == FULL_C);
  assign box_ready = (state_q == IDLE) && !full;
  assign push      = box_valid && box_ready;
  assign push_data = {box_left, box_right, box_top, box_bottom, box_tag};
  // An empty queue with a same-cycle push hands the incoming box straight through
  assign head      = (count_q == '0) ? push_data : mem[rd_ptr_q];

  assign sample_pt = (RGB_x_Src == SAMPLE_X) && (RGB_y_Src == SAMPLE_Y);
  assign switch_pt = (RGB_x_Src == SWITCH_X) && (RGB_y_Src == SWITCH_Y);

  assign left       = box_q[42:32];
  assign right      = box_q[31:21];
  assign top        = box_q[20:11];
  assign bottom     = box_q[10:1];
  assign tag        = box_q[0];
  assign res_valid  = res_valid_q;
  assign res_num    = res_num_q;
  assign res_idx    = idx_q;
  assign res_stable = res_stable_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

  // Streak/tries update for one sample of the recognizer output
  always_comb begin
    tries_n  = tries_q + 4'd1;
    last_n   = last_q;
    if (rec_num == NO_CODE) begin
      streak_n = 4'd0;
    end else if ((rec_num == last_q) && (streak_q != 4'd0)) begin
      streak_n = streak_q + 4'd1;
    end else begin
      streak_n = 4'd1;
      last_n   = rec_num;
    end
  end

  // Next-state logic for the scheduler FSM, queue pointers and result registers
  always_comb begin
    state_d      = state_q;
    box_d        = box_q;
    tries_d      = tries_q;
    streak_d     = streak_q;
    last_d       = last_q;
    idx_d        = idx_q;
    res_valid_d  = res_valid_q;
    res_num_d    = res_num_q;
    res_stable_d = res_stable_q;
    done_d       = 1'b0;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && ((count_q != '0) || push)) begin
          pop     = 1'b1;
          box_d   = head;
          idx_d   = '0;
          state_d = WAIT_SW;
        end
      end
      WAIT_SW: begin
        if (switch_pt) begin
          tries_d  = 4'd0;
          streak_d = 4'd0;
          last_d   = 4'd0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (sample_pt) begin
          tries_d  = tries_n;
          streak_d = streak_n;
          last_d   = last_n;
          if (streak_n == AGREE_C) begin
            res_valid_d  = 1'b1;
            res_num_d    = last_n;
            res_stable_d = 1'b1;
            state_d      = EMIT;
          end else if (tries_n == MAX_C) begin
            res_valid_d  = 1'b1;
            res_num_d    = NO_CODE;
            res_stable_d = 1'b0;
            state_d      = EMIT;
          end
        end
      end
      EMIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (count_q != '0) begin
            pop     = 1'b1;
            box_d   = head;
            idx_d   = idx_q + 1'b1;
            state_d = WAIT_SW;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {{IW{1'b0}}, push} - {{IW{1'b0}}, pop};
  end

  // Queue storage write; contents need no reset because the pointers are flushed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      box_q        <= '0;
      tries_q      <= '0;
      streak_q     <= '0;
      last_q       <= '0;
      idx_q        <= '0;
      res_valid_q  <= 1'b0;
      res_num_q    <= '0;
      res_stable_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      box_q        <= box_d;
      tries_q      <= tries_d;
      streak_q     <= streak_d;
      last_q       <= last_d;
      idx_q        <= idx_d;
      res_valid_q  <= res_valid_d;
      res_num_q    <= res_num_d;
      res_stable_q <= res_stable_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_recog_scheduler.sv
// tb_recog_scheduler: directed sequence with a result scoreboard for recog_scheduler.
module tb_recog_scheduler;

  localparam logic [10:0] SX  = 11'd1212;
  localparam logic [9:0]  SY  = 10'd711;
  localparam logic [10:0] WX  = 11'd1230;
  localparam logic [9:0]  WY  = 10'd713;
  localparam logic [3:0]  NOC = 4'b1011;

  logic        clk = 1'b0;
  logic        rst, start, box_valid, box_tag, res_ready;
  logic [10:0] box_left, box_right, RGB_x_Src;
  logic [9:0]  box_top, box_bottom, RGB_y_Src;
  logic [3:0]  rec_num;
  logic        box_ready, tag, res_valid, res_stable, busy, done;
  logic [10:0] left, right;
  logic [9:0]  top, bottom;
  logic [3:0]  res_num;
  logic [2:0]  res_idx;

  int checks = 0;
  int errors = 0;
  // Expected result per box: {num, idx, stable}
  logic [7:0] sb [$];

  recog_scheduler dut (
    .clk(clk), .rst(rst), .start(start),
    .box_valid(box_valid), .box_ready(box_ready),
    .box_left(box_left), .box_right(box_right), .box_top(box_top),
    .box_bottom(box_bottom), .box_tag(box_tag),
    .RGB_x_Src(RGB_x_Src), .RGB_y_Src(RGB_y_Src), .rec_num(rec_num),
    .left(left), .right(right), .top(top), .bottom(bottom), .tag(tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_num(res_num),
    .res_idx(res_idx), .res_stable(res_stable), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [42:0] bx(input int i, input logic t);
    return {11'(100 + i), 11'(300 + i), 10'(50 + i), 10'(70 + i), t};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_box(input string name, input logic [42:0] b);
    chk(name, {left, right, top, bottom, tag}, b);
  endtask

  task automatic push_box(input logic [42:0] b);
    box_valid = 1'b1;
    {box_left, box_right, box_top, box_bottom, box_tag} = b;
    cyc();
    box_valid = 1'b0;
  endtask

  // One short frame: sample point first, then switch point
  task automatic frame(input logic [3:0] n);
    rec_num = n;
    RGB_x_Src = '0; RGB_y_Src = '0;
    cyc(); cyc();
    RGB_x_Src = SX; RGB_y_Src = SY;
    cyc();
    RGB_x_Src = '0; RGB_y_Src = '0;
    cyc();
    RGB_x_Src = WX; RGB_y_Src = WY;
    cyc();
    RGB_x_Src = '0; RGB_y_Src = '0;
  endtask

  // Priming frame to reach RUN, then n samples taken from packed nibbles of seq
  task automatic run_box(input logic [63:0] seq, input int n, input logic [42:0] b,
                         input logic [3:0] en, input logic [2:0] ei, input logic es);
    sb.push_back({en, ei, es});
    frame(4'd0);
    for (int i = 0; i < n; i++) begin
      frame(seq[4*i +: 4]);
      chk($sformatf("valid_after_sample%0d", i + 1), res_valid, (i == n - 1));
    end
    chk_box("box_during_run", b);
    chk("busy_run", busy, 1'b1);
  endtask

  task automatic handshake(input bit last_box);
    logic [7:0] e;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 1'b0, 1'b1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    chk("res_valid", res_valid, 1'b1);
    chk("res_num", res_num, e[7:4]);
    chk("res_idx", res_idx, e[3:1]);
    chk("res_stable", res_stable, e[0]);
    $display("result num=%0h idx=%0d stable=%0b", res_num, res_idx, res_stable);
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    chk("res_valid_after_hs", res_valid, 1'b0);
    chk("done_after_hs", done, last_box);
    chk("busy_after_hs", busy, !last_box);
    if (last_box) begin
      cyc();
      chk("done_single_pulse", done, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; box_valid = 1'b0; res_ready = 1'b0;
    {box_left, box_right, box_top, box_bottom, box_tag} = '0;
    RGB_x_Src = '0; RGB_y_Src = '0; rec_num = '0;
    cyc(); cyc();
    chk("rst_outputs", {left, right, top, bottom, tag, res_valid, res_num, res_idx, res_stable, busy, done}, '0);
    rst = 1'b0;
    cyc();
    chk("rst_box_ready", box_ready, 1'b1);

    // Batch 1: three boxes
    push_box(bx(0, 1'b0));
    push_box(bx(1, 1'b0));
    push_box(bx(2, 1'b1));
    start = 1'b1; cyc(); start = 1'b0;
    chk("busy_start", busy, 1'b1);
    chk("box_ready_busy", box_ready, 1'b0);
    chk_box("box0_popped", bx(0, 1'b0));

    run_box(64'h555, 3, bx(0, 1'b0), 4'd5, 3'd0, 1'b1);
    for (int f = 0; f < 5; f++) begin
      frame(4'd9);
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_num", res_num, 4'd5);
    end
    chk_box("hold_box", bx(0, 1'b0));
    handshake(1'b0);
    chk_box("box1_popped", bx(1, 1'b0));

    run_box(64'h3332, 4, bx(1, 1'b0), 4'd3, 3'd1, 1'b1);
    handshake(1'b0);
    chk_box("box2_popped", bx(2, 1'b1));

    run_box(64'h2121212121, 10, bx(2, 1'b1), NOC, 3'd2, 1'b0);
    handshake(1'b1);
    chk("idle_busy", busy, 1'b0);
    chk_box("idle_holds_box", bx(2, 1'b1));

    // Start with empty queue is ignored
    start = 1'b1; cyc(); start = 1'b0;
    chk("empty_start_ignored", busy, 1'b0);

    // Fill the queue
    for (int i = 0; i < 8; i++) push_box(bx(10 + i, 1'(i)));
    chk("full_box_ready", box_ready, 1'b0);

    // Batch 2: first box times out on all no-code samples, reset during the second
    start = 1'b1; cyc(); start = 1'b0;
    chk_box("b2_box0", bx(10, 1'b0));
    run_box(64'hBBBBBBBBBB, 10, bx(10, 1'b0), NOC, 3'd0, 1'b0);
    handshake(1'b0);
    frame(4'd0);
    frame(4'd4);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midrun_rst_outputs", {left, right, top, bottom, tag, res_valid, res_num, res_idx, res_stable, busy, done}, '0);
    chk("midrun_rst_box_ready", box_ready, 1'b1);
    cyc();
    chk("midrun_no_done", done, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    chk("flushed_start_ignored", busy, 1'b0);

    // Start and push in the same cycle: batch of one
    start = 1'b1;
    push_box(bx(40, 1'b1));
    start = 1'b0;
    chk("same_cycle_busy", busy, 1'b1);
    chk_box("same_cycle_box", bx(40, 1'b1));
    run_box(64'h777, 3, bx(40, 1'b1), 4'd7, 3'd0, 1'b1);
    handshake(1'b1);
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
